// File: rtl/rob_buffer.sv
// rob_buffer: circular reorder buffer tracking in-flight instructions from dispatch to in-order commit
package general_defines;
   localparam int ROB_IDX_W       = 3;
   localparam int INSTR_MEM_IDX_W = 8;
   localparam int ARCH_REG_IDX_W  = 5;
   localparam int PHYS_REG_IDX_W  = 6;
   localparam int INT_DATA_W      = 32;
endpackage

module rob_buffer
   import general_defines::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       alloc_valid,
   output logic                       alloc_ready,
   output logic [ROB_IDX_W-1:0]       alloc_idx,
   input  logic [INSTR_MEM_IDX_W-1:0] alloc_pc,
   input  logic [INSTR_MEM_IDX_W-1:0] alloc_pred_target,
   input  logic [ARCH_REG_IDX_W-1:0]  alloc_logical_rd,
   input  logic [PHYS_REG_IDX_W-1:0]  alloc_phys_rd,
   input  logic                       alloc_is_store,
   input  logic                       alloc_is_load,
   input  logic                       alloc_is_branch,
   input  logic                       alloc_pred_taken,
   input  logic                       wb_valid,
   input  logic [ROB_IDX_W-1:0]       wb_idx,
   input  logic [INT_DATA_W-1:0]      wb_result,
   input  logic                       wb_branch_taken,
   input  logic [INSTR_MEM_IDX_W-1:0] wb_branch_target,
   output logic                       rob_head_valid,
   output logic                       rob_head_done,
   output logic [ROB_IDX_W-1:0]       rob_head_idx,
   output logic [INSTR_MEM_IDX_W-1:0] rob_head_pc,
   output logic [INSTR_MEM_IDX_W-1:0] rob_head_pred_target,
   output logic [INSTR_MEM_IDX_W-1:0] rob_head_branch_target,
   output logic [ARCH_REG_IDX_W-1:0]  rob_head_logical_rd,
   output logic [PHYS_REG_IDX_W-1:0]  rob_head_phys_rd,
   output logic [INT_DATA_W-1:0]      rob_head_result,
   output logic                       rob_head_is_store,
   output logic                       rob_head_is_load,
   output logic                       rob_head_is_branch,
   output logic                       rob_head_pred_taken,
   output logic                       rob_head_branch_taken,
   input  logic                       rob_advance_head,
   input  logic                       flush,
   output logic [ROB_IDX_W:0]         rob_count
);
   localparam int DEPTH = 2**ROB_IDX_W;

   logic [ROB_IDX_W-1:0]       head, tail;
   logic [DEPTH-1:0]           valid, done;
   logic [INSTR_MEM_IDX_W-1:0] pc_q [DEPTH];
   logic [INSTR_MEM_IDX_W-1:0] pred_target_q [DEPTH];
   logic [INSTR_MEM_IDX_W-1:0] branch_target_q [DEPTH];
   logic [ARCH_REG_IDX_W-1:0]  logical_rd_q [DEPTH];
   logic [PHYS_REG_IDX_W-1:0]  phys_rd_q [DEPTH];
   logic [INT_DATA_W-1:0]      result_q [DEPTH];
   logic [DEPTH-1:0]           is_store_q, is_load_q, is_branch_q, pred_taken_q, branch_taken_q;
   logic                       alloc_fire, retire, wb_fire;

   // Count never exceeds DEPTH, so its MSB alone marks a full buffer; reset also holds allocation off
   assign alloc_ready = rst && !rob_count[ROB_IDX_W] && !flush;
   assign alloc_idx   = tail;
   assign alloc_fire  = alloc_valid && alloc_ready;
   // Retire decides on the registered done bit, so a same-cycle writeback cannot make the head retirable
   assign retire      = !flush && rob_advance_head && rob_head_valid && rob_head_done;
   // A writeback landing on the entry being retired this cycle is dropped with the entry
   assign wb_fire     = !flush && wb_valid && valid[wb_idx] && !(retire && wb_idx == head);

   assign rob_head_valid         = (rob_count != '0) && valid[head];
   assign rob_head_done          = done[head];
   assign rob_head_idx           = head;
   assign rob_head_pc            = pc_q[head];
   assign rob_head_pred_target   = pred_target_q[head];
   assign rob_head_branch_target = branch_target_q[head];
   assign rob_head_logical_rd    = logical_rd_q[head];
   assign rob_head_phys_rd       = phys_rd_q[head];
   assign rob_head_result        = result_q[head];
   assign rob_head_is_store      = is_store_q[head];
   assign rob_head_is_load       = is_load_q[head];
   assign rob_head_is_branch     = is_branch_q[head];
   assign rob_head_pred_taken    = pred_taken_q[head];
   assign rob_head_branch_taken  = branch_taken_q[head];

   // Pointer, occupancy and status-bit bookkeeping; flush and reset both empty the buffer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head      <= '0;
         tail      <= '0;
         rob_count <= '0;
         valid     <= '0;
         done      <= '0;
      end else if (flush) begin
         head      <= '0;
         tail      <= '0;
         rob_count <= '0;
         valid     <= '0;
         done      <= '0;
      end else begin
         if (alloc_fire) begin
            tail        <= tail + 1'b1;
            valid[tail] <= 1'b1;
            done[tail]  <= 1'b0;
         end
         if (wb_fire)
            done[wb_idx] <= 1'b1;
         if (retire) begin
            head        <= head + 1'b1;
            valid[head] <= 1'b0;
            done[head]  <= 1'b0;
         end
         rob_count <= rob_count + (ROB_IDX_W+1)'(alloc_fire) - (ROB_IDX_W+1)'(retire);
      end
   end

   // Entry payload storage; contents are only meaningful while the matching valid bit is set
   always_ff @(posedge clk) begin
      if (alloc_fire) begin
         pc_q[tail]            <= alloc_pc;
         pred_target_q[tail]   <= alloc_pred_target;
         logical_rd_q[tail]    <= alloc_logical_rd;
         phys_rd_q[tail]       <= alloc_phys_rd;
         is_store_q[tail]      <= alloc_is_store;
         is_load_q[tail]       <= alloc_is_load;
         is_branch_q[tail]     <= alloc_is_branch;
         pred_taken_q[tail]    <= alloc_pred_taken;
         result_q[tail]        <= '0;
         branch_taken_q[tail]  <= 1'b0;
         branch_target_q[tail] <= '0;
      end
      if (wb_fire) begin
         result_q[wb_idx]        <= wb_result;
         branch_taken_q[wb_idx]  <= wb_branch_taken;
         branch_target_q[wb_idx] <= wb_branch_target;
      end
   end
endmodule

// File: tb/tb_rob_buffer.sv
// tb_rob_buffer: directed scenarios plus randomized traffic checked against a queue-based ROB model
module tb_rob_buffer;
   import general_defines::*;
   localparam int DEPTH = 2**ROB_IDX_W;

   typedef struct {
      int                         idx;
      logic [INSTR_MEM_IDX_W-1:0] pc, tgt, btgt;
      logic [ARCH_REG_IDX_W-1:0]  lrd;
      logic [PHYS_REG_IDX_W-1:0]  prd;
      logic                       st, ld, br, pt, bt, done;
      logic [INT_DATA_W-1:0]      res;
   } ent_t;

   logic clk = 1'b0, rst = 1'b0;
   logic alloc_valid, alloc_ready;
   logic [ROB_IDX_W-1:0] alloc_idx, wb_idx, rob_head_idx;
   logic [INSTR_MEM_IDX_W-1:0] alloc_pc, alloc_pred_target, wb_branch_target;
   logic [INSTR_MEM_IDX_W-1:0] rob_head_pc, rob_head_pred_target, rob_head_branch_target;
   logic [ARCH_REG_IDX_W-1:0] alloc_logical_rd, rob_head_logical_rd;
   logic [PHYS_REG_IDX_W-1:0] alloc_phys_rd, rob_head_phys_rd;
   logic alloc_is_store, alloc_is_load, alloc_is_branch, alloc_pred_taken;
   logic wb_valid, wb_branch_taken;
   logic [INT_DATA_W-1:0] wb_result, rob_head_result;
   logic rob_head_valid, rob_head_done, rob_head_is_store, rob_head_is_load, rob_head_is_branch;
   logic rob_head_pred_taken, rob_head_branch_taken, rob_advance_head, flush;
   logic [ROB_IDX_W:0] rob_count;

   rob_buffer dut (
      .clk(clk), .rst(rst),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
      .alloc_pc(alloc_pc), .alloc_pred_target(alloc_pred_target),
      .alloc_logical_rd(alloc_logical_rd), .alloc_phys_rd(alloc_phys_rd),
      .alloc_is_store(alloc_is_store), .alloc_is_load(alloc_is_load),
      .alloc_is_branch(alloc_is_branch), .alloc_pred_taken(alloc_pred_taken),
      .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_result(wb_result),
      .wb_branch_taken(wb_branch_taken), .wb_branch_target(wb_branch_target),
      .rob_head_valid(rob_head_valid), .rob_head_done(rob_head_done), .rob_head_idx(rob_head_idx),
      .rob_head_pc(rob_head_pc), .rob_head_pred_target(rob_head_pred_target),
      .rob_head_branch_target(rob_head_branch_target), .rob_head_logical_rd(rob_head_logical_rd),
      .rob_head_phys_rd(rob_head_phys_rd), .rob_head_result(rob_head_result),
      .rob_head_is_store(rob_head_is_store), .rob_head_is_load(rob_head_is_load),
      .rob_head_is_branch(rob_head_is_branch), .rob_head_pred_taken(rob_head_pred_taken),
      .rob_head_branch_taken(rob_head_branch_taken), .rob_advance_head(rob_advance_head),
      .flush(flush), .rob_count(rob_count)
   );

   always #5 clk = ~clk;

   int   checks = 0, errors = 0;
   ent_t q[$];
   int   mhead = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      alloc_valid = 0; alloc_pc = '0; alloc_pred_target = '0; alloc_logical_rd = '0; alloc_phys_rd = '0;
      alloc_is_store = 0; alloc_is_load = 0; alloc_is_branch = 0; alloc_pred_taken = 0;
      wb_valid = 0; wb_idx = '0; wb_result = '0; wb_branch_taken = 0; wb_branch_target = '0;
      rob_advance_head = 0; flush = 0;
   endtask

   task automatic set_alloc(input logic [INSTR_MEM_IDX_W-1:0] pc, input logic br);
      alloc_valid = 1; alloc_pc = pc; alloc_is_branch = br;
      alloc_pred_target = $urandom; alloc_logical_rd = $urandom; alloc_phys_rd = $urandom;
      alloc_is_store = $urandom; alloc_is_load = $urandom; alloc_pred_taken = $urandom;
   endtask

   task automatic set_wb(input int idx, input logic [INT_DATA_W-1:0] res);
      wb_valid = 1; wb_idx = idx[ROB_IDX_W-1:0]; wb_result = res;
      wb_branch_taken = $urandom; wb_branch_target = $urandom;
   endtask

   task automatic compare();
      check("count", rob_count, q.size());
      check("alloc_ready", alloc_ready, q.size() < DEPTH && !flush);
      check("alloc_idx", alloc_idx, (mhead + q.size()) % DEPTH);
      check("head_valid", rob_head_valid, q.size() != 0);
      if (q.size() != 0) begin
         check("head_idx", rob_head_idx, mhead);
         check("head_done", rob_head_done, q[0].done);
         check("head_pc", rob_head_pc, q[0].pc);
         check("head_pred_target", rob_head_pred_target, q[0].tgt);
         check("head_logical_rd", rob_head_logical_rd, q[0].lrd);
         check("head_phys_rd", rob_head_phys_rd, q[0].prd);
         check("head_flags", {rob_head_is_store, rob_head_is_load, rob_head_is_branch, rob_head_pred_taken},
               {q[0].st, q[0].ld, q[0].br, q[0].pt});
         check("head_result", rob_head_result, q[0].res);
         check("head_branch_taken", rob_head_branch_taken, q[0].bt);
         check("head_branch_target", rob_head_branch_target, q[0].btgt);
      end
   endtask

   // Next-state of the reference ROB as an ordered list of in-flight instructions
   task automatic model_step();
      int  t = (mhead + q.size()) % DEPTH;
      bit  can = q.size() < DEPTH;
      bit  ret;
      if (flush) begin
         q.delete();
         mhead = 0;
         return;
      end
      ret = rob_advance_head && q.size() > 0 && q[0].done;
      if (wb_valid)
         foreach (q[k])
            if (q[k].idx == int'(wb_idx) && !(ret && k == 0)) begin
               q[k].done = 1; q[k].res = wb_result; q[k].bt = wb_branch_taken; q[k].btgt = wb_branch_target;
            end
      if (ret) begin
         void'(q.pop_front());
         mhead = (mhead + 1) % DEPTH;
      end
      if (alloc_valid && can)
         q.push_back('{t, alloc_pc, alloc_pred_target, '0, alloc_logical_rd, alloc_phys_rd,
                       alloc_is_store, alloc_is_load, alloc_is_branch, alloc_pred_taken, 1'b0, 1'b0, '0});
   endtask

   task automatic cycle();
      #1 compare();
      model_step();
      @(posedge clk);
      @(negedge clk);
      idle();
   endtask

   initial begin
      idle();
      #2;
      check("rst_count", rob_count, 0);
      check("rst_head_valid", rob_head_valid, 0);
      check("rst_alloc_ready", alloc_ready, 0);
      @(negedge clk);
      rst = 1;
      #1 check("post_rst_ready", alloc_ready, 1);
      // three allocations at pc 10, 11, 12
      for (int i = 0; i < 3; i++) begin
         set_alloc(8'(10 + i), 0);
         #1 check("alloc_idx_seq", alloc_idx, i);
         cycle();
      end
      check("three_count", rob_count, 3);
      check("three_head_pc", rob_head_pc, 10);
      check("three_head_done", rob_head_done, 0);
      set_wb(1, 32'h11); cycle();
      set_wb(0, 32'h55); cycle();
      check("wb_head_done", rob_head_done, 1);
      check("wb_head_result", rob_head_result, 32'h55);
      rob_advance_head = 1; cycle();
      check("adv_head_idx", rob_head_idx, 1);
      check("adv_head_done", rob_head_done, 1);
      rob_advance_head = 1; cycle();
      check("adv_count", rob_count, 1);
      // fill to DEPTH from empty, then allocate against a retire while full
      flush = 1; cycle();
      for (int i = 0; i < DEPTH; i++) begin set_alloc(8'(32 + i), 0); cycle(); end
      check("full_ready", alloc_ready, 0);
      set_wb(0, 32'hA5); cycle();
      set_alloc(8'h77, 0); rob_advance_head = 1;
      #1 check("full_retire_ready", alloc_ready, 0);
      cycle();
      check("full_retire_count", rob_count, DEPTH - 1);
      check("wrap_ready", alloc_ready, 1);
      check("wrap_tail", alloc_idx, 0);
      // mispredicted branch: flush with retire and alloc together
      flush = 1; cycle();
      set_alloc(8'h40, 1); cycle();
      set_wb(0, 32'h1); cycle();
      check("br_head_done", rob_head_done, 1);
      flush = 1; rob_advance_head = 1; set_alloc(8'h41, 0); cycle();
      check("br_flush_count", rob_count, 0);
      check("br_flush_head_valid", rob_head_valid, 0);
      check("br_flush_tail", alloc_idx, 0);
      // invalid-index writeback, then writeback racing a retire of a not-done head
      set_alloc(8'h50, 0); cycle();
      set_alloc(8'h51, 0); cycle();
      set_wb(5, 32'hDEAD); cycle();
      check("inv_wb_count", rob_count, 2);
      check("inv_wb_head_done", rob_head_done, 0);
      set_wb(0, 32'h99); rob_advance_head = 1; cycle();
      check("race_count", rob_count, 2);
      check("race_head_idx", rob_head_idx, 0);
      // asynchronous reset mid-cycle with five entries
      for (int i = 0; i < 3; i++) begin set_alloc(8'(60 + i), 0); cycle(); end
      check("pre_arst_count", rob_count, 5);
      #2 rst = 0;
      #1;
      check("arst_count", rob_count, 0);
      check("arst_head_valid", rob_head_valid, 0);
      check("arst_ready", alloc_ready, 0);
      q.delete();
      mhead = 0;
      @(negedge clk);
      rst = 1;
      idle();
      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(99) < 65) set_alloc(8'($urandom), 1'($urandom));
         if ($urandom_range(99) < 55) begin
            if (q.size() > 0 && $urandom_range(3) != 0) set_wb(q[$urandom_range(q.size() - 1)].idx, $urandom);
            else set_wb($urandom_range(DEPTH - 1), $urandom);
         end
         rob_advance_head = $urandom_range(99) < 45;
         flush = $urandom_range(99) < 3;
         cycle();
      end
      #1 compare();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
